// File: rtl/fadd_norm_round.sv
// fadd_norm_round: two-stage normalize / round-and-pack back end of a single-precision adder.
// S1 normalizes the raw sum and S2 rounds it and packs an IEEE-754 single.
// Optional feature macro: FNR_RMODE_EN. When defined, rm selects the rounding mode.
// When undefined, rm is ignored and round-to-nearest-even is always used.
module fadd_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_frac,
  input  logic        in_inf,
  input  logic        in_nan,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_inexact
);

  localparam int unsigned EXP_W = 8;
  localparam int unsigned EXW   = EXP_W + 1;
  localparam int unsigned SIG_W = 27;
  localparam int unsigned LZ_W  = 5;

  localparam logic [1:0] RM_RN = 2'b00;
  localparam logic [1:0] RM_RZ = 2'b01;
  localparam logic [1:0] RM_RP = 2'b10;
  localparam logic [1:0] RM_RM = 2'b11;

  // Leading-zero count of a 27-bit value (27 when the value is zero).
  function automatic logic [LZ_W-1:0] lzc27(input logic [SIG_W-1:0] v);
    lzc27 = LZ_W'(SIG_W);
    for (int i = 0; i < int'(SIG_W); i++) begin
      if (v[i]) lzc27 = LZ_W'(int'(SIG_W) - 1 - i);
    end
  endfunction

  logic             s1_valid;
  logic             s1_sign;
  logic [EXW-1:0]   s1_exp;
  logic [SIG_W-1:0] s1_frac;
  logic             s1_inf;
  logic             s1_nan;
  logic [1:0]       mode;

  logic             s2_valid;
  logic             s2_adv;
  logic             s1_adv;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

`ifdef FNR_RMODE_EN
  logic [1:0] s1_rm;
  assign mode = s1_rm;

  // Rounding mode travels with its item through S1.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) s1_rm <= rm;
  end
`else
  logic unused_rm;
  assign unused_rm = ^rm;
  assign mode      = RM_RN;
`endif

  logic [EXW-1:0]   n1_exp;
  logic [SIG_W-1:0] n1_frac;
  logic [LZ_W-1:0]  lz;
  logic [LZ_W-1:0]  sh;

  // S1 normalization: carry right-shift, zero, normal left-shift or denormal clamp.
  always_comb begin
    n1_exp  = '0;
    n1_frac = '0;
    sh      = '0;
    lz      = lzc27(in_frac[SIG_W-1:0]);
    if (in_frac[27]) begin
      n1_frac = {in_frac[27:2], in_frac[1] | in_frac[0]};
      n1_exp  = EXW'(in_exp) + EXW'(1);
    end else if (in_frac[SIG_W-1:0] == '0) begin
      n1_frac = '0;
      n1_exp  = '0;
    end else if (in_exp > EXP_W'(lz)) begin
      n1_frac = in_frac[SIG_W-1:0] << lz;
      n1_exp  = EXW'(in_exp) - EXW'(lz);
    end else begin
      sh      = (in_exp == '0) ? '0 : LZ_W'(in_exp - EXP_W'(1));
      n1_frac = in_frac[SIG_W-1:0] << sh;
      n1_exp  = '0;
    end
  end

  // S1 stage register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= n1_exp;
        s1_frac <= n1_frac;
        s1_inf  <= in_inf;
        s1_nan  <= in_nan;
      end
    end
  end

  logic           lsb;
  logic           g;
  logic           rs;
  logic           inc;
  logic [24:0]    sum;
  logic [EXW-1:0] e2;
  logic [22:0]    mant;
  logic           ovf;
  logic [31:0]    n2_result;
  logic           n2_ovf;
  logic           n2_inexact;

  // S2 rounding, overflow handling and packing.
  always_comb begin
    lsb = s1_frac[3];
    g   = s1_frac[2];
    rs  = s1_frac[1] | s1_frac[0];
    case (mode)
      RM_RN:   inc = g & (rs | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RP:   inc = ~s1_sign & (g | rs);
      RM_RM:   inc = s1_sign & (g | rs);
      default: inc = 1'b0;
    endcase
    sum  = {1'b0, s1_frac[SIG_W-1:3]} + 25'(inc);
    e2   = s1_exp;
    mant = sum[22:0];
    if (sum[24]) begin
      e2   = s1_exp + EXW'(1);
      mant = sum[23:1];
    end else if (s1_exp == '0 && sum[23]) begin
      e2 = EXW'(1);
    end
    ovf        = (s1_exp >= EXW'(255)) | (e2 >= EXW'(255));
    n2_ovf     = ovf;
    n2_inexact = g | rs | ovf;
    n2_result  = {s1_sign, e2[EXP_W-1:0], mant};
    if (ovf) begin
      case (mode)
        RM_RZ:   n2_result = {s1_sign, 31'h7F7F_FFFF};
        RM_RP:   n2_result = s1_sign ? {1'b1, 31'h7F7F_FFFF} : {1'b0, 31'h7F80_0000};
        RM_RM:   n2_result = s1_sign ? {1'b1, 31'h7F80_0000} : {1'b0, 31'h7F7F_FFFF};
        default: n2_result = {s1_sign, 31'h7F80_0000};
      endcase
    end
    if (s1_nan) begin
      n2_result  = 32'h7FC0_0000;
      n2_ovf     = 1'b0;
      n2_inexact = 1'b0;
    end else if (s1_inf) begin
      n2_result  = {s1_sign, 31'h7F80_0000};
      n2_ovf     = 1'b0;
      n2_inexact = 1'b0;
    end
  end

  // S2 stage register doubles as the output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= n2_result;
        out_ovf     <= n2_ovf;
        out_inexact <= n2_inexact;
      end
    end
  end

endmodule
